// File: rtl/mips_scan_ctrl.sv
// Two-chain scan test controller: streams stimulus into both chains, pulses capture,
// and compacts the shifted-out responses into a 16-bit MISR signature.
module mips_scan_ctrl #(
    parameter int CHAIN_LEN = 64,
    parameter int MISR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       num_patterns,
    input  logic              si_valid,
    input  logic [1:0]        si_data,
    output logic              si_ready,
    output logic              test_si1,
    output logic              test_si2,
    output logic              test_se,
    input  logic              test_so1,
    input  logic              test_so2,
    output logic              scan_clk_en,
    output logic              so_valid,
    output logic [1:0]        so_data,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] signature
);

    localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [MISR_W-1:0] MISR_POLY = MISR_W'(16'h100B);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    shift_q;
    logic [15:0]         pat_q;
    logic [15:0]         npat_q;
    logic [MISR_W-1:0]   misr_q;
    logic [MISR_W-1:0]   misr_d;
    logic [15:0]         pat_d;

    // Output decode; the load path is combinational so a stalled source freezes the DUT clock.
    always_comb begin
        si_ready    = 1'b0;
        scan_clk_en = 1'b0;
        test_se     = 1'b0;
        test_si1    = 1'b0;
        test_si2    = 1'b0;
        so_valid    = 1'b0;
        case (state_q)
            S_LOAD: begin
                test_se     = 1'b1;
                si_ready    = si_valid;
                scan_clk_en = si_valid;
                test_si1    = si_data[0];
                test_si2    = si_data[1];
                // Pattern 0 shifts out whatever the chains held before the run.
                so_valid    = si_valid && (pat_q != 16'd0);
            end
            S_CAPTURE: begin
                scan_clk_en = 1'b1;
            end
            S_UNLOAD: begin
                test_se     = 1'b1;
                scan_clk_en = 1'b1;
                so_valid    = 1'b1;
            end
            default: ;
        endcase
    end

    assign so_data   = {test_so2, test_so1};
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign signature = misr_q;
    assign pat_d     = pat_q + 16'd1;

    always_comb begin
        misr_d = misr_q;
        if (so_valid) begin
            misr_d = {misr_q[MISR_W-2:0], 1'b0}
                   ^ (misr_q[MISR_W-1] ? MISR_POLY : '0)
                   ^ MISR_W'({test_so2, test_so1});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            pat_q   <= '0;
            npat_q  <= '0;
            misr_q  <= '0;
        end else begin
            misr_q <= misr_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        npat_q  <= num_patterns;
                        shift_q <= '0;
                        pat_q   <= '0;
                        misr_q  <= '0;
                        state_q <= (num_patterns == 16'd0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (si_valid) begin
                        if (shift_q == CNT_LAST) begin
                            shift_q <= '0;
                            state_q <= S_CAPTURE;
                        end else begin
                            shift_q <= shift_q + CNT_W'(1);
                        end
                    end
                end
                S_CAPTURE: begin
                    pat_q   <= pat_d;
                    state_q <= (pat_d < npat_q) ? S_LOAD : S_UNLOAD;
                end
                S_UNLOAD: begin
                    if (shift_q == CNT_LAST) begin
                        shift_q <= '0;
                        state_q <= S_DONE;
                    end else begin
                        shift_q <= shift_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_scan_ctrl.sv
// Bench for mips_scan_ctrl with CHAIN_LEN=4: a cycle-level two-chain DUT model, a
// pattern-level reference feeding a scoreboard, and a negedge monitor that pops and compares.
module tb_mips_scan_ctrl;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_patterns;
    logic        si_valid;
    logic [1:0]  si_data;
    logic        si_ready;
    logic        test_si1, test_si2, test_se;
    logic        test_so1, test_so2;
    logic        scan_clk_en;
    logic        so_valid;
    logic [1:0]  so_data;
    logic        busy, done;
    logic [15:0] signature;

    always #5 clk = ~clk;

    mips_scan_ctrl #(.CHAIN_LEN(L), .MISR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_patterns(num_patterns),
        .si_valid(si_valid), .si_data(si_data), .si_ready(si_ready),
        .test_si1(test_si1), .test_si2(test_si2), .test_se(test_se),
        .test_so1(test_so1), .test_so2(test_so2), .scan_clk_en(scan_clk_en),
        .so_valid(so_valid), .so_data(so_data), .busy(busy), .done(done),
        .signature(signature)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Combinational core logic captured into the scan cells.
    function automatic logic [L-1:0] cap1(input logic [L-1:0] a, input logic [L-1:0] b);
        return a ^ {b[L-2:0], b[L-1]};
    endfunction
    function automatic logic [L-1:0] cap2(input logic [L-1:0] a, input logic [L-1:0] b);
        return a + b;
    endfunction
    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [1:0] d);
        return {m[14:0], 1'b0} ^ (m[15] ? 16'h100B : 16'h0000) ^ {14'b0, d};
    endfunction

    // Gated DUT: two scan chains, cell L-1 drives scan-out.
    logic [L-1:0] ch1 = '0;
    logic [L-1:0] ch2 = '0;
    assign test_so1 = ch1[L-1];
    assign test_so2 = ch2[L-1];
    always @(posedge clk) begin
        if (scan_clk_en) begin
            if (test_se) begin
                ch1 <= {ch1[L-2:0], test_si1};
                ch2 <= {ch2[L-2:0], test_si2};
            end else begin
                ch1 <= cap1(ch1, ch2);
                ch2 <= cap2(ch1, ch2);
            end
        end
    end

    logic [1:0]  stim_q[$];
    logic [1:0]  exp_q[$];
    logic [15:0] exp_sig_q[$];

    int  fed, stalls, stall_left, stall_mode_g;
    int  beats, se_low, clk_en_cnt;
    bit  in_run, took, stall_now, prev_stall;
    logic [15:0] prev_sig;

    // Reference: each pattern's loaded state, its captured response, and the unload order.
    task automatic build_run(input int n, input bit want_sig);
        logic [15:0] sig;
        logic [L-1:0] v1, v2, c1, c2;
        logic [1:0] p, b;
        sig = 16'h0000;
        for (int k = 0; k < n; k++) begin
            v1 = '0;
            v2 = '0;
            for (int i = 0; i < L; i++) begin
                p = 2'($urandom_range(0, 3));
                stim_q.push_back(p);
                v1[L-1-i] = p[0];
                v2[L-1-i] = p[1];
            end
            c1 = cap1(v1, v2);
            c2 = cap2(v1, v2);
            for (int j = 0; j < L; j++) begin
                b = {c2[L-1-j], c1[L-1-j]};
                exp_q.push_back(b);
                sig = misr_step(sig, b);
            end
        end
        if (want_sig) exp_sig_q.push_back(sig);
    endtask

    // Stimulus source: stalls only mid-chain, so every stall lands in a LOAD cycle.
    initial begin
        bit stall;
        si_valid = 1'b0;
        si_data  = 2'b00;
        stall_now = 1'b0;
        forever begin
            @(posedge clk);
            if (took && stim_q.size() > 0) begin
                void'(stim_q.pop_front());
                fed++;
            end
            #1;
            stall = 1'b0;
            if (stim_q.size() > 0 && (fed % L) != 0) begin
                if (stall_mode_g == 1) stall = (fed == 2) && (stall_left > 0);
                else if (stall_mode_g == 2) stall = ($urandom_range(0, 3) == 0);
            end
            if (stall) begin
                stalls++;
                if (stall_left > 0) stall_left--;
            end
            stall_now = stall;
            si_valid  = (stim_q.size() > 0) && !stall;
            si_data   = (stim_q.size() > 0) ? stim_q[0] : 2'b00;
        end
    end

    // Monitor: pops the scoreboard whenever a response beat or a done pulse appears.
    always @(negedge clk) begin
        took = si_ready;
        if (prev_stall) chk("misr_frozen", int'(signature), int'(prev_sig));
        prev_stall = stall_now;
        prev_sig   = signature;
        if (stall_now) chk("stall_clk_en", int'(scan_clk_en), 0);
        if (si_ready) chk("scan_in_bits", int'({test_si2, test_si1}), int'(si_data));
        if (so_valid) begin
            chk("so_valid_qual", int'(scan_clk_en && test_se), 1);
            if (exp_q.size() == 0) chk("extra_beat", 1, 0);
            else chk("so_data", int'(so_data), int'(exp_q.pop_front()));
            beats++;
        end
        if (done) begin
            if (exp_sig_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("signature", int'(signature), int'(exp_sig_q.pop_front()));
        end
        if (in_run && busy && !done && !test_se) se_low++;
        if (in_run && scan_clk_en) clk_en_cnt++;
    end

    task automatic start_pulse(input int n);
        @(posedge clk); #1;
        start = 1'b1;
        num_patterns = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        num_patterns = 16'($urandom_range(0, 65535));
    endtask

    task automatic do_run(input int n, input int smode, input bit start_in_load, input string tag);
        int waited, exp_len, exp_en;
        build_run(n, 1'b1);
        fed = 0; stalls = 0; stall_left = 3; stall_mode_g = smode;
        beats = 0; se_low = 0; clk_en_cnt = 0; in_run = 1'b1;
        start_pulse(n);
        waited = 1;
        while (1) begin
            @(negedge clk);
            if (done || waited >= 2000) break;
            @(posedge clk); #1;
            waited++;
            start = start_in_load && (waited == 2);
            if (start) num_patterns = 16'(n + 3);
        end
        start = 1'b0;
        exp_len = (n == 0) ? 1 : n * (L + 1) + L + 1 + stalls;
        exp_en  = (n == 0) ? 0 : n * L + n + L;
        chk("done_cycle", waited, exp_len);
        @(posedge clk); #1;
        in_run = 1'b0;
        stall_mode_g = 0;
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("beat_count", beats, n * L);
        chk("beats_left", exp_q.size(), 0);
        chk("se_low_cycles", se_low, n);
        chk("clk_en_cycles", clk_en_cnt, exp_en);
        $display("run %-13s n=%0d stalls=%0d cycles=%0d beats=%0d sig=%04h",
                 tag, n, stalls, waited, beats, signature);
    endtask

    task automatic do_rst_run();
        int waited;
        build_run(1, 1'b0);
        fed = 0; stall_mode_g = 0;
        start_pulse(1);
        waited = 1;
        while (waited < 7) begin
            @(posedge clk); #1;
            waited++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_test_se", int'(test_se), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_clk_en", int'(scan_clk_en), 0);
        chk("rst_signature", int'(signature), 0);
        exp_q.delete();
        stim_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("no_done_after_rst", int'(done), 0);
        end
        $display("run %-13s n=1 aborted in UNLOAD cycle 2", "reset_abort");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_patterns = 16'd0;
        in_run = 1'b0; stall_mode_g = 0; fed = 0; stalls = 0; stall_left = 0;
        took = 1'b0; prev_stall = 1'b0; prev_sig = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_se", int'(test_se), 0);
        chk("reset_clk_en", int'(scan_clk_en), 0);
        chk("reset_si_ready", int'(si_ready), 0);
        chk("reset_so_valid", int'(so_valid), 0);
        chk("reset_signature", int'(signature), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_run(1, 0, 1'b0, "single");
        do_run(2, 0, 1'b0, "two_patterns");
        do_run(2, 1, 1'b0, "stall3");
        do_run(0, 0, 1'b0, "zero");
        do_run(3, 0, 1'b1, "start_in_load");
        do_rst_run();
        do_run(2, 0, 1'b0, "after_rst");
        for (int r = 0; r < 8; r++) begin
            do_run($urandom_range(1, 5), 2, 1'b0, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips_scan_ctrl.md
MIPS_SCAN_CTRL -- requirements
Module: mips_scan_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64: scan cells per chain; both chains have equal length; legal range 2..1024.
REQ-002 SHALL have parameter MISR_W, default 16: response signature width; fixed at 16.
REQ-003 clk  input  1  single clock for the controller and the gated DUT clock domain.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  single-cycle request to begin a test run; honoured only in IDLE.
REQ-006 num_patterns  input  16  number of patterns in the run; sampled when start is accepted.
REQ-007 si_valid  input  1  stimulus bit-pair available.
REQ-008 si_data  input  2  stimulus bits: [0] to chain 1, [1] to chain 2.
REQ-009 si_ready  output  1  stimulus bit-pair consumed this cycle.
REQ-010 test_si1 / test_si2  output  1 each  scan-in bits to the DUT.
REQ-011 test_se  output  1  scan enable to the DUT.
REQ-012 test_so1 / test_so2  input  1 each  scan-out bits from the DUT.
REQ-013 scan_clk_en  output  1  DUT clock-gate enable; the DUT shifts or captures on the clk edge ending a cycle with scan_clk_en=1.
REQ-014 so_valid  output  1  response bit-pair valid.
REQ-015 so_data  output  2  response bits: {test_so2, test_so1}.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at the end of a run.
REQ-018 signature  output  16  MISR contents; stable from the done pulse until the next accepted start.

Function
REQ-019 SHALL implement the FSM states IDLE, LOAD, CAPTURE, UNLOAD and DONE.
REQ-020 IDLE -> LOAD on start with num_patterns>0; the transition clears the shift counter, the pattern counter and the MISR.
REQ-021 IDLE -> DONE on start with num_patterns=0; the MISR is cleared.
REQ-022 In LOAD, test_se=1, and si_ready = scan_clk_en = si_valid (combinational).
REQ-023 In LOAD, test_si1/test_si2 = si_data[0]/si_data[1] (combinational); the shift counter increments only when a bit-pair is consumed.
REQ-024 A LOAD stall (si_valid=0) freezes the DUT (scan_clk_en=0), the counters and the MISR.
REQ-025 LOAD -> CAPTURE after CHAIN_LEN bit-pairs are consumed.
REQ-026 CAPTURE lasts exactly one cycle with test_se=0, scan_clk_en=1, si_ready=0 and the pattern counter incremented.
REQ-027 CAPTURE -> LOAD when the pattern counter is below num_patterns; otherwise CAPTURE -> UNLOAD.
REQ-028 In UNLOAD, test_se=1, scan_clk_en=1 every cycle, test_si1=test_si2=0 and si_ready=0, for CHAIN_LEN cycles; then UNLOAD -> DONE.
REQ-029 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-030 so_valid=1 only in cycles with scan_clk_en=1 and test_se=1 in LOAD of pattern 1 or later, or in UNLOAD.
REQ-031 Bit-pairs shifted while loading pattern 0 SHALL never assert so_valid or update the MISR.
REQ-032 Exactly CHAIN_LEN*num_patterns bit-pairs SHALL be reported per run.
REQ-033 MISR update when so_valid=1: next = (misr<<1) ^ (misr[15] ? 16'h100B : 16'h0000) ^ {14'b0, test_so2, test_so1}; held otherwise.
REQ-034 In IDLE and DONE, test_se=0, scan_clk_en=0, si_ready=0 and test_si1=test_si2=0.
REQ-035 start is ignored while busy=1.
REQ-036 num_patterns changes after start is accepted have no effect on the run.
REQ-037 The shift counter covers 0..CHAIN_LEN-1 without wrap at CHAIN_LEN=1024.
REQ-038 The pattern counter is 16 bits; num_patterns=65535 completes without overflow.

Reset
REQ-039 rst=1 at a clk edge forces IDLE, clears both counters and the MISR, and sets test_se=0, scan_clk_en=0, si_ready=0, so_valid=0, busy=0 and done=0.
REQ-040 rst asserted mid-run aborts the run without a done pulse; the first clk edge with rst=0 leaves the block in IDLE, ready for start.

Verification (CHAIN_LEN=4)
REQ-041 Run num_patterns=1, si_valid held 1, DUT modelled as two 4-bit shift registers -> 4 LOAD, 1 CAPTURE, 4 UNLOAD cycles; done pulses in cycle 10 after start; 4 so_valid beats; signature matches the reference model.
REQ-042 Run num_patterns=2 -> LOAD pattern 1 overlaps unload of response 0; 8 so_valid beats total; test_se low in exactly 2 cycles of the run.
REQ-043 Drop si_valid for 3 cycles mid-LOAD -> scan_clk_en=0, counters frozen and MISR unchanged for those 3 cycles; run length grows by exactly 3 cycles.
REQ-044 start with num_patterns=0 -> done the next cycle, signature=16'h0000, scan_clk_en never 1.
REQ-045 rst in the 2nd UNLOAD cycle -> next cycle busy=0, test_se=0, no done pulse; a new start runs normally.
REQ-046 start pulsed during LOAD -> ignored; pattern count and done timing unchanged.
